// File: rtl/hack_pkg.sv
// Shared Hack definitions: instruction/ROM widths and the ROM loader state encoding.
package hack_pkg;

   localparam int INST_W     = 16;
   localparam int ROM_ADDR_W = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   // States in which the loader owns the byte stream (accepts bytes, reports busy).
   function automatic logic is_load_state(input loader_state_t s);
      return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
   endfunction

endpackage

// File: rtl/hack_idle_timer.sv
// Idle watchdog: counts enabled cycles since the last clear and flags the cycle that completes LIMIT.
module hack_idle_timer #(
   parameter int unsigned LIMIT = 1_000_000,
   parameter int          CNT_W = 32
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // LIMIT==0 disables expiry; otherwise the LIMIT-th idle cycle raises the flag.
   assign expired_o = (LIMIT != 0) && en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/hack_rom_loader.sv
// Hack ROM loader: parses LEN_HI/LEN_LO, 2N big-endian data bytes and an XOR checksum, writing ROM from 0.
module hack_rom_loader import hack_pkg::*; #(
   parameter int          ADDR_W         = ROM_ADDR_W,
   parameter int          INST_W         = hack_pkg::INST_W,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   output logic                rom_we,
   output logic [ADDR_W-1:0]   rom_addr,
   output logic [INST_W-1:0]   rom_wdata,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_loaded,
   output loader_state_t       dbg_state
);

   // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready is a
   // registered decode of the state and never depends combinationally on in_valid.

   loader_state_t     state_q, state_d;
   logic              load_q;
   logic              rom_we_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [INST_W-1:0] rom_wdata_q;
   logic              cpu_hold_q, done_q, error_q;
   logic [ADDR_W:0]   words_q;
   logic [ADDR_W:0]   len_q;
   logic [7:0]        hi_q;
   logic [7:0]        acc_q;

   logic        accept;
   logic        timeout;
   logic [15:0] n_len;
   logic        len_ok;
   logic        last_word;

   assign accept    = in_valid && load_q;
   assign n_len     = {hi_q, in_data};
   assign len_ok    = (n_len != 16'd0) && ({16'd0, n_len} <= (32'd1 << ADDR_W));
   // words_q is ADDR_W+1 bits wide so a full 2**ADDR_W program reaches CSUM without wrapping.
   assign last_word = ((words_q + (ADDR_W+1)'(1)) == len_q);

   hack_idle_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (accept || !load_q),
      .en_i      (load_q),
      .expired_o (timeout)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start)  state_d = ST_LEN_HI;
         ST_LEN_HI:                if (accept) state_d = ST_LEN_LO;
         ST_LEN_LO:                if (accept) state_d = len_ok ? ST_DATA_HI : ST_ERR;
         ST_DATA_HI:               if (accept) state_d = ST_DATA_LO;
         ST_DATA_LO:               if (accept) state_d = last_word ? ST_CSUM : ST_DATA_HI;
         ST_CSUM:                  if (accept) state_d = (in_data == acc_q) ? ST_DONE : ST_ERR;
         default:                  state_d = ST_IDLE;
      endcase
      if (timeout) state_d = ST_ERR;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         load_q      <= 1'b0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         cpu_hold_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         words_q     <= '0;
         len_q       <= '0;
         hi_q        <= '0;
         acc_q       <= '0;
      end else begin
         state_q    <= state_d;
         load_q     <= is_load_state(state_d);
         done_q     <= (state_d == ST_DONE);
         error_q    <= (state_d == ST_ERR);
         cpu_hold_q <= (state_d != ST_DONE);
         rom_we_q   <= 1'b0;

         if (start && state_q inside {ST_IDLE, ST_DONE, ST_ERR}) begin
            words_q <= '0;
            acc_q   <= '0;
         end

         if (accept) begin
            if (state_q != ST_CSUM) acc_q <= acc_q ^ in_data;
            if (state_q inside {ST_LEN_HI, ST_DATA_HI}) hi_q <= in_data;
            if (state_q == ST_LEN_LO) len_q <= (ADDR_W+1)'(n_len);
            if (state_q == ST_DATA_LO) begin
               rom_we_q    <= 1'b1;
               rom_addr_q  <= words_q[ADDR_W-1:0];
               rom_wdata_q <= INST_W'({hi_q, in_data});
               words_q     <= words_q + (ADDR_W+1)'(1);
            end
         end
      end
   end

   assign in_ready     = load_q;
   assign busy         = load_q;
   assign rom_we       = rom_we_q;
   assign rom_addr     = rom_addr_q;
   assign rom_wdata    = rom_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: table of byte streams with hand-computed results plus corner sequences.
module tb_hack_rom_loader;
   import hack_pkg::*;

   localparam int AW = 4;
   localparam int TO = 50;
   localparam int NV = 7;

   logic            clk, rst, start, in_valid;
   logic [7:0]      in_data;
   logic            in_ready, rom_we, cpu_hold, busy, done, error;
   logic [AW-1:0]   rom_addr;
   logic [15:0]     rom_wdata;
   logic [AW:0]     words_loaded;
   loader_state_t   dbg_state;

   hack_rom_loader #(.ADDR_W(AW), .INST_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   int we_cnt = 0;
   logic [AW+15:0] got_q[$];
   logic [AW+15:0] exp_q[$];

   always @(negedge clk) begin
      if (rom_we === 1'b1) begin
         got_q.push_back({rom_addr, rom_wdata});
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct packed {
      int               n;
      logic [0:39][7:0] b;
      bit               thr;
      bit               e_done;
      int               e_words;
      int               n_exp;
      logic [0:15][15:0] w;
   } vec_t;

   vec_t vecs[NV];

   // ---------------- driver tasks ----------------
   int t_acc;

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit thr);
      int w;
      if (thr) repeat ($urandom_range(0, 3)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) begin
         chk("in_ready_wait", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 t_acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   t_first;
      logic [AW+15:0] e, g;
      v = vecs[idx];
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < v.n_exp; i++) exp_q.push_back({AW'(i), v.w[i]});
      pulse_start();
      chk($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'd1);
      chk($sformatf("v%0d_done_cleared", idx), 32'(done), 32'd0);
      t_first = 0;
      for (int i = 0; i < v.n; i++) begin
         send_byte(v.b[i], v.thr);
         if (i == 0) t_first = t_acc;
      end
      if (!v.thr && v.n > 2)
         chk($sformatf("v%0d_one_byte_per_cycle", idx), 32'(t_acc - t_first), 32'(v.n - 1));
      @(negedge clk);
      chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.e_done));
      chk($sformatf("v%0d_error", idx), 32'(error), 32'(!v.e_done));
      chk($sformatf("v%0d_cpu_hold", idx), 32'(cpu_hold), 32'(!v.e_done));
      chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d_in_ready_end", idx), 32'(in_ready), 32'd0);
      chk($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.e_words));
      chk($sformatf("v%0d_write_count", idx), 32'(got_q.size()), 32'(v.n_exp));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         chk($sformatf("v%0d_write", idx), 32'(g), 32'(e));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int we0, w;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

      // Stream checksums below: 00^02^EC^10^00^07 = F9; 00^01^AB^CD = 67; pairs {i,i} cancel so N=16 gives 10.
      for (int k = 0; k < NV; k++) vecs[k] = '0;
      vecs[0].n = 7;  vecs[0].b[0:6] = {8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h07, 8'hF9};
      vecs[0].e_done = 1; vecs[0].e_words = 2; vecs[0].n_exp = 2; vecs[0].w[0:1] = {16'hEC10, 16'h0007};
      vecs[1] = vecs[0]; vecs[1].b[6] = 8'hFA; vecs[1].e_done = 0;
      vecs[2].n = 2;  vecs[2].b[0:1] = {8'h00, 8'h00};
      vecs[3].n = 2;  vecs[3].b[0:1] = {8'h00, 8'h11};
      vecs[4].n = 35; vecs[4].b[0:1] = {8'h00, 8'h10}; vecs[4].b[34] = 8'h10; vecs[4].thr = 1;
      vecs[4].e_done = 1; vecs[4].e_words = 16; vecs[4].n_exp = 16;
      for (int i = 0; i < 16; i++) begin
         vecs[4].b[2 + 2*i] = 8'(i);
         vecs[4].b[3 + 2*i] = 8'(i);
         vecs[4].w[i] = {8'(i), 8'(i)};
      end
      vecs[5] = vecs[0]; vecs[5].thr = 1;
      vecs[6].n = 5;  vecs[6].b[0:4] = {8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67};
      vecs[6].e_done = 1; vecs[6].e_words = 1; vecs[6].n_exp = 1; vecs[6].w[0] = 16'hABCD;

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset with no start.
      we0 = we_cnt;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0 || i == 99) begin
            chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done_error", 32'({done, error}), 32'd0);
            chk("idle_words", 32'(words_loaded), 32'd0);
            chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));
         end
      end
      chk("idle_no_rom_we", 32'(we_cnt - we0), 32'd0);

      for (int k = 0; k < NV; k++) run_vec(k);

      // Timeout: N=4, stop after three data bytes.
      got_q.delete();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h04, 0);
      send_byte(8'hEC, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
      w = 0;
      while (error !== 1'b1 && w < 200) begin
         @(negedge clk);
         if (error !== 1'b1) w++;
      end
      chk("timeout_fired", 32'(error), 32'd1);
      chk("timeout_latency", 32'(cyc - t_acc), 32'(TO));
      chk("timeout_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("timeout_words", 32'(words_loaded), 32'd1);
      chk("timeout_writes", 32'(got_q.size()), 32'd1);

      // Async reset while waiting for a DATA_LO byte.
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'hEC, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
      chk("pre_reset_state", 32'(dbg_state), 32'(ST_DATA_LO));
      rst = 1'b1;
      #1;
      chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("async_rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("async_rst_outputs", 32'({in_ready, rom_we, busy, done, error}), 32'd0);
      chk("async_rst_words", 32'(words_loaded), 32'd0);
      chk("async_rst_rom_bus", 32'({rom_addr, rom_wdata}), 32'd0);
      @(negedge clk);
      we0 = we_cnt;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_write_after_reset", 32'(we_cnt - we0), 32'd0);
      run_vec(0);

      // Start pulse mid-load must be ignored.
      got_q.delete();
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      pulse_start();
      chk("start_busy_state", 32'(dbg_state), 32'(ST_DATA_HI));
      send_byte(8'hEC, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h07, 0); send_byte(8'hF9, 0);
      @(negedge clk);
      chk("start_busy_done", 32'(done), 32'd1);
      chk("start_busy_words", 32'(words_loaded), 32'd2);
      chk("start_busy_writes", 32'(got_q.size()), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
